// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline control unit for the 5-stage MIPS datapath. It tracks a shadow
// copy of the destination and control info held in the EX, MEM and WB stages.
// From that shadow state it produces:
//   - load-use stalls,
//   - taken-branch flushes,
//   - EX-stage forwarding selects for both ALU operands.
// Two saturating counters record stall and flush events for performance debug.
module hazard_stall_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    // ------------------------------------------------------------------
    // Shadow pipeline state
    // ------------------------------------------------------------------
    logic              ex_valid_reg;
    logic [REG_AW-1:0] ex_rs_reg;
    logic [REG_AW-1:0] ex_rt_reg;
    logic [REG_AW-1:0] ex_rd_reg;
    logic              ex_rw_reg;
    logic              ex_mr_reg;

    logic              mem_valid_reg;
    logic [REG_AW-1:0] mem_rd_reg;
    logic              mem_rw_reg;

    logic              wb_valid_reg;
    logic [REG_AW-1:0] wb_rd_reg;
    logic              wb_rw_reg;

    logic [CNT_W-1:0]  stall_count_reg;
    logic [CNT_W-1:0]  stall_count_next;
    logic [CNT_W-1:0]  flush_count_reg;
    logic [CNT_W-1:0]  flush_count_next;

    // ------------------------------------------------------------------
    // Hazard detection and priority resolution
    // ------------------------------------------------------------------
    logic rs_match;
    logic rt_match;
    logic load_use;
    logic flush;
    logic stall_event;
    logic bubble_int;

    // Load in EX whose destination feeds an operand of the instruction in ID.
    // An invalid ID slot never stalls, and $0 is never a real dependency.
    always_comb begin
        rs_match = id_uses_rs && (id_rs == ex_rd_reg);
        rt_match = id_uses_rt && (id_rt == ex_rd_reg);
        load_use = id_valid && ex_valid_reg && ex_mr_reg &&
                   (ex_rd_reg != '0) && (rs_match || rt_match);
        flush    = ex_branch_taken;
        // A flush kills the ID instruction, so a coincident load-use is moot.
        stall_event = load_use && !flush;
        bubble_int  = flush || load_use;
    end

    // Drive the pipeline control outputs. Flush beats stall. Reset forces
    // the normal-flow values so the datapath keeps fetching.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!reset) begin
            if (flush) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: one identical selector per ALU operand
    // ------------------------------------------------------------------
    logic [REG_AW-1:0] ex_src [2];
    logic [1:0]        fwd_sel [2];

    assign ex_src[0] = ex_rs_reg;
    assign ex_src[1] = ex_rt_reg;

    // The MEM and WB hit terms reach through the shadow stages.
    // MEM holds the younger result, so it takes precedence.
    // Register 0 is hardwired and must never be forwarded.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic mem_hit;
        logic wb_hit;

        // Select the youngest in-flight producer of this operand.
        always_comb begin
            mem_hit = mem_valid_reg && mem_rw_reg && (mem_rd_reg != '0) &&
                      (mem_rd_reg == ex_src[gi]);
            wb_hit  = wb_valid_reg && wb_rw_reg && (wb_rd_reg != '0) &&
                      (wb_rd_reg == ex_src[gi]);
            fwd_sel[gi] = FWD_REGFILE;
            if (reset) begin
                fwd_sel[gi] = FWD_REGFILE;
            end else if (mem_hit) begin
                fwd_sel[gi] = FWD_EXMEM;
            end else if (wb_hit) begin
                fwd_sel[gi] = FWD_MEMWB;
            end
        end
    end

    assign fwd_a_sel = fwd_sel[0];
    assign fwd_b_sel = fwd_sel[1];

    // ------------------------------------------------------------------
    // Shadow stage advance
    // ------------------------------------------------------------------

    // EX captures the ID instruction unless a bubble is inserted. In that
    // case only the valid bit drops and the fields are left as they were.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_reg <= 1'b0;
            ex_rs_reg    <= '0;
            ex_rt_reg    <= '0;
            ex_rd_reg    <= '0;
            ex_rw_reg    <= 1'b0;
            ex_mr_reg    <= 1'b0;
        end else if (bubble_int) begin
            ex_valid_reg <= 1'b0;
        end else begin
            ex_valid_reg <= id_valid;
            ex_rs_reg    <= id_rs;
            ex_rt_reg    <= id_rt;
            ex_rd_reg    <= id_rd;
            ex_rw_reg    <= id_reg_write;
            ex_mr_reg    <= id_mem_read;
        end
    end

    // MEM and WB shift unconditionally; the datapath never stalls them.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_reg <= 1'b0;
            mem_rd_reg    <= '0;
            mem_rw_reg    <= 1'b0;
            wb_valid_reg  <= 1'b0;
            wb_rd_reg     <= '0;
            wb_rw_reg     <= 1'b0;
        end else begin
            mem_valid_reg <= ex_valid_reg;
            mem_rd_reg    <= ex_rd_reg;
            mem_rw_reg    <= ex_rw_reg;
            wb_valid_reg  <= mem_valid_reg;
            wb_rd_reg     <= mem_rd_reg;
            wb_rw_reg     <= mem_rw_reg;
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------

    // Next counter values. Once a counter is all ones it holds there.
    always_comb begin
        stall_count_next = stall_count_reg;
        flush_count_next = flush_count_reg;
        if (stall_event && !(&stall_count_reg)) begin
            stall_count_next = stall_count_reg + 1'b1;
        end
        if (flush && !(&flush_count_reg)) begin
            flush_count_next = flush_count_reg + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            stall_count_reg <= stall_count_next;
            flush_count_reg <= flush_count_next;
        end
    end

    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS datapath (SCDataPath).
- Keeps a shadow pipeline of destination/control info for the EX, MEM and WB stages.
- From that shadow state it generates load-use stalls, branch flushes, and EX-stage forwarding selects.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, width of stall/flush counters

Ports:
clk  in  1  datapath clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_AW  ID source register rs
id_rt  in  REG_AW  ID source register rt
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_rd  in  REG_AW  ID destination register (post RegDst mux)
id_reg_write  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
ex_branch_taken  in  1  branch in EX resolved taken this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  zero the IF/ID register
idex_bubble  out  1  load a NOP into ID/EX
fwd_a_sel  out  2  ALU operand A source: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b_sel  out  2  ALU operand B source, same encoding
stall_count  out  CNT_W  cycles stalled on load-use, saturating
flush_count  out  CNT_W  taken-branch flushes, saturating

Behaviour:

Shadow stage registers:
- EX stage holds {valid, rs, rt, rd, rw, mr}.
- MEM and WB stages each hold {valid, rd, rw}.

Advance on each edge when reset=0:
- WB <= MEM.
- MEM <= EX.
- EX <= {id_valid, id_*} when idex_bubble=0; otherwise EX.valid <= 0.

Hazard terms (combinational from inputs and shadow state):
- load_use = id_valid & EX.valid & EX.mr & EX.rd!=0 & ((id_uses_rs & id_rs==EX.rd) | (id_uses_rt & id_rt==EX.rd)).
- flush = ex_branch_taken.

Output control, priority flush > load_use > normal:
- flush: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
- load_use only: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1. The stall lasts exactly 1 cycle, because the load moves to MEM on the next edge.
- normal: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.

Forwarding (operand A shown; B is identical using EX.rt):
- 10 if MEM.valid & MEM.rw & MEM.rd!=0 & MEM.rd==EX.rs.
- else 01 if WB.valid & WB.rw & WB.rd!=0 & WB.rd==EX.rs.
- else 00.
- MEM always wins over WB when both match.
- Register 0 is never forwarded.

Counters:
- stall_count +1 on each edge where load_use=1 and flush=0.
- flush_count +1 on each edge where flush=1.
- Both saturate at 2^CNT_W-1; no wrap.

Reset:
- On an edge with reset=1, all shadow valids and both counters go to 0.
- While reset=1, outputs are forced to pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, fwd_*=00, regardless of inputs.
- Reset asserted mid-stall or mid-flush: state is cleared at that edge. No residual stall follows, since the EX shadow is invalid.

Other rules:
- id_valid=0 never causes a stall and is shadowed as a bubble.
- Simultaneous load_use and flush: flush only. The ID instruction is killed, and stall_count does not increment.

Test Plan:
1. Reset for 2 cycles, then idle (id_valid=0) for 5 cycles -> pc_write=1, ifid_write=1, idex_bubble=0, fwd_a_sel=fwd_b_sel=00, both counters 0.
2. lw $8 in ID, next cycle add $9,$8,$10 in ID -> exactly 1 cycle with pc_write=0, ifid_write=0, idex_bubble=1. On the next cycle the add proceeds, and when it is in EX fwd_a_sel=01. stall_count=1.
3. add $3,$1,$2 followed by sub $4,$3,$3 -> no stall; with sub in EX, fwd_a_sel=fwd_b_sel=10. Insert one independent instruction between them -> both selects =01.
4. Back-to-back writers to $5, then a reader of $5 -> fwd_a_sel=10 (MEM priority over WB). A writer to $0 followed by a reader of $0 -> selects 00, no stall.
5. ex_branch_taken=1 in the same cycle as a load_use pattern -> ifid_flush=1, idex_bubble=1, pc_write=1, flush_count=1, stall_count unchanged.
6. Drive load_use continuously with CNT_W overridden to 4 -> stall_count stops at 15. Assert reset mid-sequence -> on the next cycle counters are 0 and pc_write=1.
